// File: rtl/regfile_2w2r_sb.sv
// Parametrised 2-read/2-write register file with per-register busy scoreboard.
// Optional same-cycle write-to-read bypass under macro REGFILE_BYPASS_EN.
module regfile_2w2r_sb #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  Busy1,
    output logic                  Busy2,
    input  logic [ADDR_WIDTH-1:0] WriteRegisterA,
    input  logic [DATA_WIDTH-1:0] WriteDataA,
    input  logic                  RegWriteA,
    input  logic [ADDR_WIDTH-1:0] WriteRegisterB,
    input  logic [DATA_WIDTH-1:0] WriteDataB,
    input  logic                  RegWriteB,
    input  logic [ADDR_WIDTH-1:0] IssueRegister,
    input  logic                  Issue
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_busy;

    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_iss;
    logic [ADDR_WIDTH-1:0] w_ra [2];
    logic [DATA_WIDTH-1:0] w_rd [2];
    logic [1:0]            w_rb;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (HARDWIRE_ZERO != 0) && (a == '0);
    endfunction

    assign w_wr_a = RegWriteA && !is_zero(WriteRegisterA);
    assign w_wr_b = RegWriteB && !is_zero(WriteRegisterB);
    assign w_iss  = Issue && !is_zero(IssueRegister);

    // A is applied after B so it wins an address collision; issue beats retire.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_b) begin
                r_regs[WriteRegisterB] <= WriteDataB;
                r_busy[WriteRegisterB] <= 1'b0;
            end
            if (w_wr_a) begin
                r_regs[WriteRegisterA] <= WriteDataA;
                r_busy[WriteRegisterA] <= 1'b0;
            end
            if (w_iss) begin
                r_busy[IssueRegister] <= 1'b1;
            end
        end
    end

    assign w_ra[0] = ReadRegister1;
    assign w_ra[1] = ReadRegister2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = r_regs[w_ra[p]];
            w_rb[p] = r_busy[w_ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (!Reset && w_wr_b && (WriteRegisterB == w_ra[p])) begin
                w_rd[p] = WriteDataB;
                w_rb[p] = w_iss && (IssueRegister == w_ra[p]);
            end
            if (!Reset && w_wr_a && (WriteRegisterA == w_ra[p])) begin
                w_rd[p] = WriteDataA;
                w_rb[p] = w_iss && (IssueRegister == w_ra[p]);
            end
`endif
            if (is_zero(w_ra[p])) begin
                w_rd[p] = '0;
                w_rb[p] = 1'b0;
            end
        end
    end

    assign ReadData1 = w_rd[0];
    assign ReadData2 = w_rd[1];
    assign Busy1     = w_rb[0];
    assign Busy2     = w_rb[1];

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed plus randomized scoreboard bench for regfile_2w2r_sb.
module tb_regfile_2w2r_sb;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic [31:0] ReadData1, ReadData2;
    logic        Busy1, Busy2;
    logic [4:0]  WriteRegisterA, WriteRegisterB, IssueRegister;
    logic [31:0] WriteDataA, WriteDataB;
    logic        RegWriteA, RegWriteB, Issue;

    regfile_2w2r_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .HARDWIRE_ZERO(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Busy1(Busy1), .Busy2(Busy2),
        .WriteRegisterA(WriteRegisterA), .WriteDataA(WriteDataA),
        .RegWriteA(RegWriteA),
        .WriteRegisterB(WriteRegisterB), .WriteDataB(WriteDataB),
        .RegWriteB(RegWriteB),
        .IssueRegister(IssueRegister), .Issue(Issue)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    task automatic idle();
        Reset = 0; RegWriteA = 0; RegWriteB = 0; Issue = 0;
        WriteRegisterA = 0; WriteRegisterB = 0; IssueRegister = 0;
        WriteDataA = 0; WriteDataB = 0;
    endtask

    // Reference model: expected read values in the current cycle.
    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!Reset && RegWriteA && WriteRegisterA == a) return WriteDataA;
        if (!Reset && RegWriteB && WriteRegisterB == a) return WriteDataB;
`endif
        return m_regs[a];
    endfunction

    function automatic logic m_bz(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (!Reset && ((RegWriteA && WriteRegisterA == a) ||
                       (RegWriteB && WriteRegisterB == a)))
            return Issue && IssueRegister == a;
`endif
        return m_busy[a];
    endfunction

    task automatic m_commit();
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_busy = 0;
        end else begin
            if (RegWriteA && WriteRegisterA != 0) begin
                m_regs[WriteRegisterA] = WriteDataA;
                m_busy[WriteRegisterA] = 1'b0;
            end
            if (RegWriteB && WriteRegisterB != 0 &&
                !(RegWriteA && WriteRegisterA == WriteRegisterB)) begin
                m_regs[WriteRegisterB] = WriteDataB;
                m_busy[WriteRegisterB] = 1'b0;
            end
            if (Issue && IssueRegister != 0) m_busy[IssueRegister] = 1'b1;
        end
    endtask

    task automatic tick();
        m_commit();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] d1,
                        input logic [31:0] d2, input logic b1, input logic b2);
        exp_t e;
        e.tag = t; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2;
        q.push_back(e);
    endtask

    task automatic push_model(input string t);
        push(t, m_rd(ReadRegister1), m_rd(ReadRegister2),
             m_bz(ReadRegister1), m_bz(ReadRegister2));
    endtask

    task automatic chk();
        exp_t e;
        #1;
        n_cmp++;
        assert (q.size() != 0) else begin
            n_bad++;
            $error("FAIL queue_empty got 0 entries required 1");
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            n_cmp += 4;
            assert (ReadData1 === e.d1) else begin
                n_bad++;
                $error("FAIL %s rd1 got %h required %h", e.tag, ReadData1, e.d1);
            end
            assert (ReadData2 === e.d2) else begin
                n_bad++;
                $error("FAIL %s rd2 got %h required %h", e.tag, ReadData2, e.d2);
            end
            assert (Busy1 === e.b1) else begin
                n_bad++;
                $error("FAIL %s busy1 got %b required %b", e.tag, Busy1, e.b1);
            end
            assert (Busy2 === e.b2) else begin
                n_bad++;
                $error("FAIL %s busy2 got %b required %b", e.tag, Busy2, e.b2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hDEAD_BEEF;
        m_busy = '1;
        idle();
        ReadRegister1 = 0; ReadRegister2 = 0;
        @(negedge Clk);

        Reset = 1;
        push("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); idle();
        ReadRegister1 = 5; ReadRegister2 = 31;
        chk();

        RegWriteA = 1; WriteRegisterA = 26; WriteDataA = 32'h8000007F;
        push("basic", 32'h8000007F, 32'h8000007F, 1'b0, 1'b0);
        tick(); idle();
        ReadRegister1 = 26; ReadRegister2 = 26;
        chk();
        ReadRegister1 = 19;
        push("untouched", 32'h0, 32'h8000007F, 1'b0, 1'b0);
        chk();

        RegWriteA = 1; WriteRegisterA = 7; WriteDataA = 32'hAAAA0000;
        RegWriteB = 1; WriteRegisterB = 7; WriteDataB = 32'h5555FFFF;
        push("conflict", 32'hAAAA0000, 32'hAAAA0000, 1'b0, 1'b0);
        tick(); idle();
        ReadRegister1 = 7; ReadRegister2 = 7;
        chk();

        RegWriteA = 1; WriteRegisterA = 0; WriteDataA = 32'hFFFFFFFF;
        RegWriteB = 1; WriteRegisterB = 0; WriteDataB = 32'hFFFFFFFF;
        Issue = 1; IssueRegister = 0;
        ReadRegister1 = 0; ReadRegister2 = 0;
        push("zero_same", 32'h0, 32'h0, 1'b0, 1'b0);
        chk();
        push("zero", 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); idle();
        chk();

        Issue = 1; IssueRegister = 19;
        push("issue", 32'h0, 32'hAAAA0000, 1'b1, 1'b0);
        tick(); idle();
        ReadRegister1 = 19; ReadRegister2 = 7;
        chk();

        RegWriteB = 1; WriteRegisterB = 19; WriteDataB = 32'hD83F003F;
        push("retire_b", 32'hD83F003F, 32'hAAAA0000, 1'b0, 1'b0);
        tick(); idle();
        chk();

        Issue = 1; IssueRegister = 19;
        RegWriteA = 1; WriteRegisterA = 19; WriteDataA = 32'h11112222;
        push("issue_and_write", 32'h11112222, 32'hAAAA0000, 1'b1, 1'b0);
        tick(); idle();
        chk();

        Issue = 1; IssueRegister = 19;
        push("reissue", 32'h11112222, 32'hAAAA0000, 1'b1, 1'b0);
        tick(); idle();
        chk();

        ReadRegister1 = 3; ReadRegister2 = 4;
        RegWriteA = 1; WriteRegisterA = 3; WriteDataA = 32'h12345678;
`ifdef REGFILE_BYPASS_EN
        push("bypass_same", 32'h12345678, 32'h0, 1'b0, 1'b0);
`else
        push("bypass_same", 32'h0, 32'h0, 1'b0, 1'b0);
`endif
        chk();
        push("bypass_next", 32'h12345678, 32'h0, 1'b0, 1'b0);
        tick(); idle();
        chk();

        Issue = 1; IssueRegister = 10;
        RegWriteA = 1; WriteRegisterA = 11; WriteDataA = 32'hCAFE0011;
        tick(); idle();
        Reset = 1;
        Issue = 1; IssueRegister = 13;
        RegWriteA = 1; WriteRegisterA = 12; WriteDataA = 32'h0BAD0012;
        ReadRegister1 = 12; ReadRegister2 = 10;
        push("reset_mid_same", 32'h0, 32'h0, 1'b0, 1'b1);
        chk();
        tick(); idle();
        push("reset_mid_a", 32'h0, 32'h0, 1'b0, 1'b0);
        chk();
        ReadRegister1 = 11; ReadRegister2 = 13;
        push("reset_mid_b", 32'h0, 32'h0, 1'b0, 1'b0);
        chk();

        for (int n = 0; n < 300; n++) begin
            Reset          = ($urandom_range(0, 39) == 0);
            RegWriteA      = $urandom_range(0, 1);
            RegWriteB      = $urandom_range(0, 1);
            Issue          = $urandom_range(0, 1);
            WriteRegisterA = 5'($urandom_range(0, 7));
            WriteRegisterB = 5'($urandom_range(0, 7));
            IssueRegister  = 5'($urandom_range(0, 7));
            WriteDataA     = $urandom;
            WriteDataB     = $urandom;
            ReadRegister1  = 5'($urandom_range(0, 7));
            ReadRegister2  = 5'($urandom_range(0, 7));
            push_model("random");
            chk();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule
